// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver FSM states,
// default oversampling ratio and LCR data-length encoding.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [1:0] DLS_5 = 2'b00;
  localparam logic [1:0] DLS_6 = 2'b01;
  localparam logic [1:0] DLS_7 = 2'b10;
  localparam logic [1:0] DLS_8 = 2'b11;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_STOP2  = 3'd5
  } rx_state_t;

  // Index of the last data bit of a frame (bit count minus one).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] dls);
    logic [2:0] idx;
    case (dls)
      DLS_5:   idx = 3'd4;
      DLS_6:   idx = 3'd5;
      DLS_7:   idx = 3'd6;
      DLS_8:   idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

  // par is the XOR of the data bits, p the received parity bit.
  function automatic logic parity_error(input logic par, input logic p, input logic even);
    return even ? (par ^ p) : ~(par ^ p);
  endfunction

endpackage

// File: rtl/uart_receive_if.sv
// LCR fields forwarded by uart_ctrl into the receiver and the receiver's
// data/status levels returned to uart_ctrl.
interface uart_receive_if;
  logic [1:0] ctrl_receive_data_length;
  logic       ctrl_receive_parity_en;
  logic       ctrl_receive_parity_bit;
  logic       ctrl_receive_stop_length;
  logic [7:0] receive_ctrl_rdata;
  logic       receive_ctrl_redata_over;
  logic       receive_ctrl_pe;
  logic       receive_ctrl_fe;
  logic       receive_ctrl_busy;

  modport master (
    output ctrl_receive_data_length, ctrl_receive_parity_en,
           ctrl_receive_parity_bit, ctrl_receive_stop_length,
    input  receive_ctrl_rdata, receive_ctrl_redata_over,
           receive_ctrl_pe, receive_ctrl_fe, receive_ctrl_busy
  );

  modport slave (
    input  ctrl_receive_data_length, ctrl_receive_parity_en,
           ctrl_receive_parity_bit, ctrl_receive_stop_length,
    output receive_ctrl_rdata, receive_ctrl_redata_over,
           receive_ctrl_pe, receive_ctrl_fe, receive_ctrl_busy
  );
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; presets high
// on reset so an idle line never looks like a start bit.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift chain, preset to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= {STAGES{1'b1}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_receive.sv
// UART serial receive engine: oversampled start/data/parity/stop framing
// with level status flags held until the next valid start edge.
module uart_receive
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          baud_receive_tick,
  input  logic          uart_sin,
  uart_receive_if.slave bus
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam logic [TCW-1:0] TICK_MID  = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);

  rx_state_t      state, state_nxt;
  logic [TCW-1:0] tick_cnt, tick_nxt;
  logic [2:0]     bit_cnt, bit_nxt;
  logic [7:0]     shreg, shreg_nxt;
  logic [7:0]     rdata, rdata_nxt;
  logic [2:0]     f_last, f_last_nxt;
  logic           f_pen, f_pen_nxt, f_eps, f_eps_nxt, f_stop2, f_stop2_nxt;
  logic           par, par_nxt, perr, perr_nxt, armed, armed_nxt;
  logic           done, done_nxt, pe, pe_nxt, fe, fe_nxt, busy, busy_nxt;
  logic           sin, mid;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (sys_clk),
    .rst (rst),
    .d   (uart_sin),
    .q   (sin)
  );

  // Mid-bit sample point once a frame is bit-aligned.
  assign mid = baud_receive_tick && (tick_cnt == TICK_LAST);

  // Next-state, counter, shift and flag logic.
  always_comb begin
    state_nxt   = state;
    tick_nxt    = tick_cnt;
    bit_nxt     = bit_cnt;
    shreg_nxt   = shreg;
    rdata_nxt   = rdata;
    f_last_nxt  = f_last;
    f_pen_nxt   = f_pen;
    f_eps_nxt   = f_eps;
    f_stop2_nxt = f_stop2;
    par_nxt     = par;
    perr_nxt    = perr;
    armed_nxt   = armed;
    done_nxt    = done;
    pe_nxt      = pe;
    fe_nxt      = fe;
    busy_nxt    = busy;
    case (state)
      RX_IDLE: begin
        if (!armed) begin
          armed_nxt = sin;
        end else if (baud_receive_tick && !sin) begin
          state_nxt   = RX_START;
          tick_nxt    = {TCW{1'b0}};
          busy_nxt    = 1'b1;
          armed_nxt   = 1'b0;
          done_nxt    = 1'b0;
          pe_nxt      = 1'b0;
          fe_nxt      = 1'b0;
          shreg_nxt   = 8'h00;
          par_nxt     = 1'b0;
          perr_nxt    = 1'b0;
          f_last_nxt  = last_bit_idx(bus.ctrl_receive_data_length);
          f_pen_nxt   = bus.ctrl_receive_parity_en;
          f_eps_nxt   = bus.ctrl_receive_parity_bit;
          f_stop2_nxt = bus.ctrl_receive_stop_length;
        end else begin
          armed_nxt = 1'b1;
        end
      end
      RX_START: begin
        if (baud_receive_tick && (tick_cnt == TICK_MID)) begin
          tick_nxt = {TCW{1'b0}};
          bit_nxt  = 3'd0;
          if (sin) begin
            state_nxt = RX_IDLE;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = RX_DATA;
          end
        end else begin
          tick_nxt = tick_cnt + TCW'(baud_receive_tick);
        end
      end
      // From here the counter wraps to 0 exactly at each mid-bit sample.
      RX_DATA: begin
        tick_nxt = tick_cnt + TCW'(baud_receive_tick);
        if (mid) begin
          shreg_nxt = {sin, shreg[7:1]};
          par_nxt   = par ^ sin;
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == f_last) begin
            state_nxt = f_pen ? RX_PARITY : RX_STOP;
          end else begin
            state_nxt = RX_DATA;
          end
        end else begin
          state_nxt = RX_DATA;
        end
      end
      RX_PARITY: begin
        tick_nxt = tick_cnt + TCW'(baud_receive_tick);
        if (mid) begin
          perr_nxt  = parity_error(par, sin, f_eps);
          state_nxt = RX_STOP;
        end else begin
          state_nxt = RX_PARITY;
        end
      end
      RX_STOP: begin
        tick_nxt = tick_cnt + TCW'(baud_receive_tick);
        if (mid) begin
          rdata_nxt = shreg;
          fe_nxt    = ~sin;
          pe_nxt    = perr;
          done_nxt  = 1'b1;
          if (f_stop2) begin
            state_nxt = RX_STOP2;
          end else begin
            state_nxt = RX_IDLE;
            busy_nxt  = 1'b0;
          end
        end else begin
          state_nxt = RX_STOP;
        end
      end
      // Second stop bit is half length for 5-bit frames; its value is ignored.
      RX_STOP2: begin
        if (baud_receive_tick && (tick_cnt == ((f_last == 3'd4) ? TICK_MID : TICK_LAST))) begin
          state_nxt = RX_IDLE;
          busy_nxt  = 1'b0;
          tick_nxt  = {TCW{1'b0}};
        end else begin
          tick_nxt = tick_cnt + TCW'(baud_receive_tick);
        end
      end
      default: begin
        state_nxt = RX_IDLE;
        busy_nxt  = 1'b0;
        tick_nxt  = {TCW{1'b0}};
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= RX_IDLE;
      tick_cnt <= {TCW{1'b0}};
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      rdata    <= 8'h00;
      f_last   <= 3'd0;
      f_pen    <= 1'b0;
      f_eps    <= 1'b0;
      f_stop2  <= 1'b0;
      par      <= 1'b0;
      perr     <= 1'b0;
      armed    <= 1'b0;
      done     <= 1'b0;
      pe       <= 1'b0;
      fe       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      rdata    <= rdata_nxt;
      f_last   <= f_last_nxt;
      f_pen    <= f_pen_nxt;
      f_eps    <= f_eps_nxt;
      f_stop2  <= f_stop2_nxt;
      par      <= par_nxt;
      perr     <= perr_nxt;
      armed    <= armed_nxt;
      done     <= done_nxt;
      pe       <= pe_nxt;
      fe       <= fe_nxt;
      busy     <= busy_nxt;
    end
  end

  assign bus.receive_ctrl_rdata       = rdata;
  assign bus.receive_ctrl_redata_over = done;
  assign bus.receive_ctrl_pe          = pe;
  assign bus.receive_ctrl_fe          = fe;
  assign bus.receive_ctrl_busy        = busy;

endmodule

// File: tb/tb_uart_receive.sv
// Directed self-checking bench for uart_receive: frames are driven bit by
// bit with a baud tick every other clock (16 ticks = 32 clocks per bit).
module tb_uart_receive;
  import uart_pkg::*;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic tick    = 1'b0;
  logic sin     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   done_rises = 0;
  logic prev_done = 1'b0;
  int   base;

  uart_receive_if rif ();

  uart_receive #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .sys_clk           (sys_clk),
    .rst               (rst),
    .baud_receive_tick (tick),
    .uart_sin          (sin),
    .bus               (rif)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    forever begin
      @(negedge sys_clk);
      tick = ~tick;
    end
  end

  // Count rising edges of the frame-done level.
  always @(posedge sys_clk) begin
    prev_done <= rif.receive_ctrl_redata_over;
    if (rif.receive_ctrl_redata_over && !prev_done) begin
      done_rises <= done_rises + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (2 * n) @(negedge sys_clk);
  endtask

  task automatic set_lcr(input logic [1:0] dls, input logic pen, input logic eps, input logic stb);
    rif.ctrl_receive_data_length = dls;
    rif.ctrl_receive_parity_en   = pen;
    rif.ctrl_receive_parity_bit  = eps;
    rif.ctrl_receive_stop_length = stb;
  endtask

  // Drives start, data (LSB first) and optional parity; returns at the start
  // of the first stop bit with the line high.
  task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                            input logic even, input logic bad_par, input int dls_change_at);
    logic ones;
    ones = 1'b0;
    sin = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      sin  = data[i];
      ones = ones ^ data[i];
      wait_ticks(16);
      if (i == dls_change_at) rif.ctrl_receive_data_length = DLS_5;
    end
    if (pen) begin
      sin = (even ? ones : ~ones) ^ bad_par;
      wait_ticks(16);
    end
    sin = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (rif.receive_ctrl_redata_over !== 1'b1 && n < 64) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq(tag, rif.receive_ctrl_redata_over, 1'b1);
  endtask

  initial begin
    set_lcr(DLS_8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge sys_clk);
    check_eq("rst_rdata", rif.receive_ctrl_rdata, 8'h00);
    check_eq("rst_done",  rif.receive_ctrl_redata_over, 1'b0);
    check_eq("rst_pe",    rif.receive_ctrl_pe, 1'b0);
    check_eq("rst_fe",    rif.receive_ctrl_fe, 1'b0);
    check_eq("rst_busy",  rif.receive_ctrl_busy, 1'b0);
    rst = 1'b0;
    wait_ticks(8);

    // 8N1 0xA5
    base = done_rises;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, -1);
    check_eq("t1_busy_pre", rif.receive_ctrl_busy, 1'b1);
    wait_done("t1_done");
    check_eq("t1_busy_fall", rif.receive_ctrl_busy, 1'b0);
    check_eq("t1_rdata", rif.receive_ctrl_rdata, 8'hA5);
    check_eq("t1_pe", rif.receive_ctrl_pe, 1'b0);
    check_eq("t1_fe", rif.receive_ctrl_fe, 1'b0);
    wait_ticks(10);
    check_eq("t1_rises", done_rises - base, 1);

    // 5E1, good then bad parity
    set_lcr(DLS_5, 1'b1, 1'b1, 1'b0);
    send_frame(8'h16, 5, 1'b1, 1'b1, 1'b0, -1);
    check_eq("t2_done_cleared", rif.receive_ctrl_redata_over, 1'b0);
    wait_done("t2_done");
    check_eq("t2_rdata", rif.receive_ctrl_rdata, 8'hB0);
    check_eq("t2_pe", rif.receive_ctrl_pe, 1'b0);
    wait_ticks(10);
    send_frame(8'h16, 5, 1'b1, 1'b1, 1'b1, -1);
    wait_done("t2b_done");
    check_eq("t2b_rdata", rif.receive_ctrl_rdata, 8'hB0);
    check_eq("t2b_pe", rif.receive_ctrl_pe, 1'b1);
    check_eq("t2b_fe", rif.receive_ctrl_fe, 1'b0);
    wait_ticks(10);

    // 7O2 0x41
    set_lcr(DLS_7, 1'b1, 1'b0, 1'b1);
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b0, -1);
    check_eq("t3_pe_cleared", rif.receive_ctrl_pe, 1'b0);
    wait_done("t3_done");
    check_eq("t3_rdata", rif.receive_ctrl_rdata, 8'h82);
    check_eq("t3_pe", rif.receive_ctrl_pe, 1'b0);
    check_eq("t3_busy_hold", rif.receive_ctrl_busy, 1'b1);
    wait_ticks(14);
    check_eq("t3_busy_14", rif.receive_ctrl_busy, 1'b1);
    wait_ticks(4);
    check_eq("t3_busy_18", rif.receive_ctrl_busy, 1'b0);
    check_eq("t3_done_held", rif.receive_ctrl_redata_over, 1'b1);
    wait_ticks(8);

    // Glitch: short low pulse is a false start
    set_lcr(DLS_8, 1'b0, 1'b0, 1'b0);
    base = done_rises;
    sin = 1'b0;
    wait_ticks(3);
    check_eq("t4_busy", rif.receive_ctrl_busy, 1'b1);
    check_eq("t4_done_cleared", rif.receive_ctrl_redata_over, 1'b0);
    wait_ticks(1);
    sin = 1'b1;
    wait_ticks(10);
    check_eq("t4_busy_drop", rif.receive_ctrl_busy, 1'b0);
    check_eq("t4_done", rif.receive_ctrl_redata_over, 1'b0);
    check_eq("t4_rises", done_rises - base, 0);
    wait_ticks(8);

    // Break: line low for 20 bit times
    base = done_rises;
    sin = 1'b0;
    wait_ticks(16 * 15);
    check_eq("t5_done", rif.receive_ctrl_redata_over, 1'b1);
    check_eq("t5_rdata", rif.receive_ctrl_rdata, 8'h00);
    check_eq("t5_fe", rif.receive_ctrl_fe, 1'b1);
    check_eq("t5_busy", rif.receive_ctrl_busy, 1'b0);
    wait_ticks(16 * 5);
    check_eq("t5_no_restart", rif.receive_ctrl_busy, 1'b0);
    check_eq("t5_rises", done_rises - base, 1);
    sin = 1'b1;
    wait_ticks(16);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, -1);
    check_eq("t5_fe_cleared", rif.receive_ctrl_fe, 1'b0);
    wait_done("t5b_done");
    check_eq("t5b_rdata", rif.receive_ctrl_rdata, 8'h55);
    check_eq("t5b_fe", rif.receive_ctrl_fe, 1'b0);
    wait_ticks(10);

    // Reset during data bit 3, then a clean frame with a mid-frame DLS change
    base = done_rises;
    sin = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      sin = (8'h3C >> i) & 8'h01;
      wait_ticks(16);
    end
    sin = 1'b1;
    wait_ticks(8);
    rst = 1'b1;
    @(negedge sys_clk);
    check_eq("t6_rdata", rif.receive_ctrl_rdata, 8'h00);
    check_eq("t6_done", rif.receive_ctrl_redata_over, 1'b0);
    check_eq("t6_pe", rif.receive_ctrl_pe, 1'b0);
    check_eq("t6_fe", rif.receive_ctrl_fe, 1'b0);
    check_eq("t6_busy", rif.receive_ctrl_busy, 1'b0);
    rst = 1'b0;
    wait_ticks(32);
    check_eq("t6_no_partial", done_rises - base, 0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 2);
    wait_done("t6b_done");
    check_eq("t6b_rdata", rif.receive_ctrl_rdata, 8'h3C);
    check_eq("t6b_fe", rif.receive_ctrl_fe, 1'b0);
    check_eq("t6b_pe", rif.receive_ctrl_pe, 1'b0);
    check_eq("t6b_busy", rif.receive_ctrl_busy, 1'b0);
    wait_ticks(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
